// File: rtl/perf_counter_sequencer_pkg.sv
// Shared types and constants for the performance-counter command sequencer.
package perf_counter_sequencer_pkg;

  // Sequencer FSM states: one write state, four snapshot-read states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4,
    RD3  = 3'd5
  } state_e;

  // Register offsets inside one counter section and the section stride.
  localparam logic [3:0] STOP_OFS   = 4'd0;
  localparam logic [3:0] GO_OFS     = 4'd1;
  localparam logic [3:0] EVT_OFS    = 4'd2;
  localparam logic [3:0] SEC_STRIDE = 4'd4;

  // Data word written to address 0 to clear every counter.
  localparam logic [31:0] CLR_DATA = 32'd1;

  // Slave address of register 'ofs' inside section 'sec'.
  function automatic logic [3:0] sec_addr(input logic [1:0] sec, input logic [3:0] ofs);
    return ({2'b00, sec} * SEC_STRIDE) + ofs;
  endfunction

endpackage

// File: rtl/perf_rr_arbiter.sv
// Round-robin arbiter over the section requests; the pointer moves past the
// granted section only when the sequencer actually accepts the grant.
module perf_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  logic [1:0] ptr_r;
  logic [1:0] idx_s;
  logic       found_s;
  logic       hit_s;

  // Pick the first requester at or above the pointer, else wrap to the lowest one.
  always_comb begin
    grant   = '0;
    idx_s   = 2'd0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_s    = req[i] && !found_s && (i >= int'(ptr_r));
      grant[i] = grant[i] | hit_s;
      idx_s    = hit_s ? 2'(i) : idx_s;
      found_s  = found_s | hit_s;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_s    = req[i] && !found_s;
      grant[i] = grant[i] | hit_s;
      idx_s    = hit_s ? 2'(i) : idx_s;
      found_s  = found_s | hit_s;
    end
  end

  // Pointer register: advance to the section after the accepted one.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 2'd0;
    end else if (accept) begin
      ptr_r <= (idx_s == 2'(NUM_REQ - 1)) ? 2'd0 : idx_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/perf_counter_sequencer.sv
// Sequencer that turns per-section go/stop, global clear and snapshot
// requests into single Avalon-MM accesses on the counter control slave.
module perf_counter_sequencer
  import perf_counter_sequencer_pkg::*;
#(
  parameter int NUM_SEC = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SEC-1:0] go_req,
  input  logic [NUM_SEC-1:0] stop_req,
  output logic [NUM_SEC-1:0] sec_ack,
  input  logic               clr_req,
  output logic               clr_ack,
  input  logic               snap_req,
  input  logic [1:0]         snap_sel,
  output logic               snap_valid,
  output logic [63:0]        snap_time,
  output logic [31:0]        snap_events,
  output logic [3:0]         avm_address,
  output logic               avm_write,
  output logic               avm_begintransfer,
  output logic [31:0]        avm_writedata,
  input  logic [31:0]        avm_readdata
);

  state_e             state_r, state_s;
  logic [1:0]         sel_r, sel_s;
  logic [NUM_SEC-1:0] sec_ack_r, sec_ack_s;
  logic               clr_ack_r, clr_ack_s;
  logic               snap_valid_r, snap_valid_s;
  logic [63:0]        snap_time_r, snap_time_s;
  logic [31:0]        snap_events_r, snap_events_s;
  logic [3:0]         addr_r, addr_s;
  logic               write_r, write_s;
  logic [31:0]        wdata_r, wdata_s;

  logic [NUM_SEC-1:0] sec_req_s;
  logic [NUM_SEC-1:0] sec_grant_s;
  logic               accept_s;
  logic [1:0]         gnt_idx_s;
  logic               is_stop_s;
  logic               sel_ok_s;
  logic [31:0]        rd_word_s;

  assign sec_req_s = go_req | stop_req;
  assign accept_s  = (state_r == IDLE) && !clr_req && !snap_req && (|sec_req_s);
  assign is_stop_s = |(sec_grant_s & stop_req);
  assign sel_ok_s  = int'(sel_r) < NUM_SEC;
  // Sections that do not exist read back as zero.
  assign rd_word_s = sel_ok_s ? avm_readdata : 32'd0;

  perf_rr_arbiter #(.NUM_REQ(NUM_SEC)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (sec_req_s),
    .accept (accept_s),
    .grant  (sec_grant_s)
  );

  // Encode the one-hot section grant into an index.
  always_comb begin
    gnt_idx_s = 2'd0;
    for (int i = 0; i < NUM_SEC; i++) begin
      gnt_idx_s = sec_grant_s[i] ? 2'(i) : gnt_idx_s;
    end
  end

  // Next state plus next values of every registered output; pulses default low.
  always_comb begin
    state_s       = state_r;
    sel_s         = sel_r;
    sec_ack_s     = '0;
    clr_ack_s     = 1'b0;
    snap_valid_s  = 1'b0;
    snap_time_s   = snap_time_r;
    snap_events_s = snap_events_r;
    addr_s        = 4'd0;
    write_s       = 1'b0;
    wdata_s       = 32'd0;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_s   = WR;
          addr_s    = 4'd0;
          wdata_s   = CLR_DATA;
          write_s   = 1'b1;
          clr_ack_s = 1'b1;
        end else if (snap_req) begin
          state_s = RD0;
          sel_s   = snap_sel;
          addr_s  = sec_addr(snap_sel, STOP_OFS);
        end else if (|sec_req_s) begin
          state_s   = WR;
          addr_s    = sec_addr(gnt_idx_s, is_stop_s ? STOP_OFS : GO_OFS);
          write_s   = 1'b1;
          sec_ack_s = sec_grant_s;
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        state_s = IDLE;
      end
      RD0: begin
        state_s = RD1;
        addr_s  = sec_addr(sel_r, GO_OFS);
      end
      RD1: begin
        state_s           = RD2;
        addr_s            = sec_addr(sel_r, EVT_OFS);
        snap_time_s[31:0] = rd_word_s;
      end
      RD2: begin
        state_s            = RD3;
        snap_time_s[63:32] = rd_word_s;
        // Valid is raised for the RD3 cycle; the events word lands at its end.
        snap_valid_s       = 1'b1;
      end
      RD3: begin
        state_s       = IDLE;
        snap_events_s = rd_word_s;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      sel_r         <= 2'd0;
      sec_ack_r     <= '0;
      clr_ack_r     <= 1'b0;
      snap_valid_r  <= 1'b0;
      snap_time_r   <= 64'd0;
      snap_events_r <= 32'd0;
      addr_r        <= 4'd0;
      write_r       <= 1'b0;
      wdata_r       <= 32'd0;
    end else begin
      state_r       <= state_s;
      sel_r         <= sel_s;
      sec_ack_r     <= sec_ack_s;
      clr_ack_r     <= clr_ack_s;
      snap_valid_r  <= snap_valid_s;
      snap_time_r   <= snap_time_s;
      snap_events_r <= snap_events_s;
      addr_r        <= addr_s;
      write_r       <= write_s;
      wdata_r       <= wdata_s;
    end
  end

  assign sec_ack           = sec_ack_r;
  assign clr_ack           = clr_ack_r;
  assign snap_valid        = snap_valid_r;
  assign snap_time         = snap_time_r;
  assign snap_events       = snap_events_r;
  assign avm_address       = addr_r;
  assign avm_write         = write_r;
  assign avm_begintransfer = write_r;
  assign avm_writedata     = wdata_r;

endmodule

// File: doc/perf_counter_sequencer.md
PERF_COUNTER_SEQUENCER -- requirements
Module: perf_counter_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_SEC, default 3, meaning the number of counter sections driven; legal range is 1..4.
REQ-002 The block SHALL have port clk, input, width 1: the single clock.
REQ-003 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-004 The block SHALL have port go_req, input, width NUM_SEC: level request per section to start its time counter.
REQ-005 The block SHALL have port stop_req, input, width NUM_SEC: level request per section to stop its time counter.
REQ-006 The block SHALL have port sec_ack, output, width NUM_SEC: 1-cycle pulse when that section's command has been issued.
REQ-007 The block SHALL have port clr_req, input, width 1: level request for a global clear of all counters.
REQ-008 The block SHALL have port clr_ack, output, width 1: 1-cycle pulse when the clear has been issued.
REQ-009 The block SHALL have ports snap_req (input, 1) and snap_sel (input, 2): level request to read section snap_sel.
REQ-010 The block SHALL have ports snap_valid (output, 1), snap_time (output, 64) and snap_events (output, 32): the snapshot result.
REQ-011 The block SHALL have ports avm_address (output, 4), avm_write (output, 1), avm_begintransfer (output, 1), avm_writedata (output, 32) and avm_readdata (input, 32): the counter control-slave master.

Function
REQ-012 FSM states SHALL be IDLE, WR, RD0, RD1, RD2, RD3.
- Every state SHALL return to IDLE.
- Grants SHALL be evaluated only in IDLE.
REQ-013 IDLE priority SHALL be: clr_req, then snap_req, then section requests.
- Section requests SHALL use a round-robin pointer, and the pointer SHALL advance past the granted section.
REQ-014 A section is requesting when go_req[s] | stop_req[s]; if both are asserted, stop SHALL win.
REQ-015 WR SHALL last exactly 1 cycle, driving avm_write=1 and avm_begintransfer=1.
- Stop: avm_address=4s, avm_writedata=0.
- Go: avm_address=4s+1, avm_writedata=0.
- Clear: avm_address=0, avm_writedata=1.
REQ-016 The matching ack SHALL pulse in the same cycle as the WR strobe; the requester drops its request after the ack.
- A request still high in the following IDLE cycle SHALL be treated as a new request.
REQ-017 Snapshot read sequence, with readdata valid one cycle after its address:
- RD0: avm_address=4*snap_sel.
- RD1: avm_address=4*snap_sel+1; capture time[31:0].
- RD2: avm_address=4*snap_sel+2; capture time[63:32].
- RD3: capture events[31:0]; snap_valid=1 for 1 cycle.
REQ-018 snap_sel SHALL be latched on grant.
- snap_sel >= NUM_SEC SHALL complete the sequence and return zeros.
- avm_write SHALL be 0 in every RD state.
REQ-019 Outside WR: avm_write=0, avm_begintransfer=0, avm_writedata=0.
- In IDLE, avm_address SHALL hold 0.
REQ-020 snap_time and snap_events SHALL hold their last value until the next snap_valid.
REQ-021 Latency: a grant in IDLE at cycle N SHALL give WR at N+1, or RD0 at N+1 with snap_valid at N+4.
- Back-to-back commands SHALL spend at least one IDLE cycle between them.

Reset
REQ-022 While reset=1, the block SHALL hold:
- FSM state = IDLE; round-robin pointer = 0.
- All acks, snap_valid, avm_write and avm_begintransfer = 0.
- avm_address, avm_writedata, snap_time and snap_events = 0.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence without issuing an ack or snap_valid; requests are re-arbitrated afterwards.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enum;
- the address offsets STOP_OFS=0, GO_OFS=1, EVT_OFS=2 and SEC_STRIDE=4;
- the clear data constant 1.
REQ-025 Round-robin selection SHALL be the sub-module perf_rr_arbiter (NUM_SEC requests in, one-hot grant out, pointer update on accept).

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- go_req[1]=1 -> one WR cycle with address=5, writedata=0, write=begintransfer=1, and sec_ack[1] in the same cycle.
- go_req=3'b111 held, pointer=0 -> WR addresses 1, 5, 9 in that order, each separated by one IDLE cycle.
- clr_req and go_req[0] asserted together -> clear issued first (address 0, writedata 1), then go_req[0] (address 1).
- snap_sel=2 with readdata model returning 0x11, 0x22, 0x33 -> snap_time=0x00000022_00000011, snap_events=0x33, snap_valid at grant+4.
- go_req[2] and stop_req[2] both high -> single WR at address 8.
- Reset pulse during RD1 -> no snap_valid; IDLE next cycle; all outputs 0.
